// File: rtl/alarm_zone_ctrl.sv
// Multi-zone alarm sequencer: per-zone debounce, bypass masking, exit/entry
// delays, fixed-priority trip arbitration, timed siren and a trip-event port.
module alarm_zone_ctrl #(
  parameter int NZONES      = 4,
  parameter int DEBOUNCE    = 3,
  parameter int EXIT_DELAY  = 16,
  parameter int ENTRY_DELAY = 16,
  parameter int SIREN_TIME  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              arm_req,
  input  logic              disarm_req,
  input  logic [NZONES-1:0] zone_in,
  input  logic [NZONES-1:0] zone_mask,
  output logic              siren,
  output logic              armed,
  output logic              tripped,
  output logic [2:0]        state,
  output logic              evt_valid,
  output logic [2:0]        evt_zone,
  input  logic              evt_ready,
  output logic              evt_overflow
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_SIREN    = 3'd4
  } state_e;

  localparam int MAX_A     = (EXIT_DELAY > ENTRY_DELAY) ? EXIT_DELAY : ENTRY_DELAY;
  localparam int MAX_DELAY = (MAX_A > SIREN_TIME) ? MAX_A : SIREN_TIME;
  localparam int CW        = (MAX_DELAY > 1) ? $clog2(MAX_DELAY) : 1;
  localparam int DCW       = $clog2(DEBOUNCE + 1);

  state_e                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [NZONES-1:0][DCW-1:0]   deb_cnt;
  logic [NZONES-1:0]            deb;
  logic [NZONES-1:0]            act;
  logic [2:0]                   win;
  logic                         push;
  logic                         accept;

  assign state  = state_q;
  assign act    = deb & ~zone_mask;
  assign accept = evt_valid & evt_ready;
  assign push   = (state_q == S_ARMED) && (|act) && !disarm_req;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    win = '0;
    for (int i = NZONES - 1; i >= 0; i--) begin
      if (act[i]) win = 3'(i);
    end
  end

  // deb[i] rises on the same edge the counter reaches DEBOUNCE, hence the -1 look-ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the debounce counter array is reset explicitly; a stale count would fake a trip after reset.
      deb_cnt <= '0;
      deb     <= '0;
    end else begin
      for (int i = 0; i < NZONES; i++) begin
        if (!zone_in[i]) begin
          deb_cnt[i] <= '0;
          deb[i]     <= 1'b0;
        end else begin
          if (deb_cnt[i] != DCW'(DEBOUNCE)) deb_cnt[i] <= deb_cnt[i] + 1'b1;
          deb[i] <= (deb_cnt[i] >= DCW'(DEBOUNCE - 1));
        end
      end
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_DISARMED;
      cnt_q        <= '0;
      siren        <= 1'b0;
      armed        <= 1'b0;
      tripped      <= 1'b0;
      evt_valid    <= 1'b0;
      evt_zone     <= '0;
      evt_overflow <= 1'b0;
    end else begin
      if (disarm_req) begin
        state_q <= S_DISARMED;
        cnt_q   <= '0;
        siren   <= 1'b0;
        armed   <= 1'b0;
        tripped <= 1'b0;
      end else begin
        case (state_q)
          S_DISARMED: begin
            if (arm_req) begin
              state_q <= S_EXIT;
              cnt_q   <= CW'(EXIT_DELAY - 1);
            end
          end
          S_EXIT: begin
            if (cnt_q == '0) begin
              state_q <= S_ARMED;
              armed   <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_ARMED: begin
            if (|act) begin
              state_q <= S_ENTRY;
              cnt_q   <= CW'(ENTRY_DELAY - 1);
            end
          end
          S_ENTRY: begin
            if (cnt_q == '0) begin
              state_q <= S_SIREN;
              cnt_q   <= CW'(SIREN_TIME - 1);
              siren   <= 1'b1;
              tripped <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          S_SIREN: begin
            if (cnt_q == '0) begin
              state_q <= S_ARMED;
              siren   <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          default: begin
            state_q <= S_DISARMED;
            cnt_q   <= '0;
            siren   <= 1'b0;
            armed   <= 1'b0;
          end
        endcase
      end

      // A pending event survives disarm; only the overflow flag is cleared.
      if (push) begin
        if (!evt_valid || accept) begin
          evt_valid <= 1'b1;
          evt_zone  <= win;
        end else begin
          evt_overflow <= 1'b1;
        end
      end else if (accept) begin
        evt_valid <= 1'b0;
      end
      if (disarm_req) evt_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alarm_zone_ctrl.sv
// Directed bench for alarm_zone_ctrl: a vector table for arm, debounce and
// priority behaviour, plus hand sequences for full trip, races and reset.
module tb_alarm_zone_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       arm_req, disarm_req, evt_ready;
  logic [3:0] zone_in, zone_mask;
  logic       siren, armed, tripped, evt_valid, evt_overflow;
  logic [2:0] state, evt_zone;

  int n_cmp  = 0;
  int n_fail = 0;

  alarm_zone_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm_req      (arm_req),
    .disarm_req   (disarm_req),
    .zone_in      (zone_in),
    .zone_mask    (zone_mask),
    .siren        (siren),
    .armed        (armed),
    .tripped      (tripped),
    .state        (state),
    .evt_valid    (evt_valid),
    .evt_zone     (evt_zone),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       arm;
    logic       disarm;
    logic       ready;
    logic [3:0] zin;
    logic [3:0] mask;
    int         hold;
    logic [2:0] st;
    logic       armed;
    logic       valid;
    logic [2:0] zone;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"},    8'(state), 8'd0);
    check({tag, ".siren"},    8'(siren), 8'd0);
    check({tag, ".armed"},    8'(armed), 8'd0);
    check({tag, ".tripped"},  8'(tripped), 8'd0);
    check({tag, ".valid"},    8'(evt_valid), 8'd0);
    check({tag, ".zone"},     8'(evt_zone), 8'd0);
    check({tag, ".overflow"}, 8'(evt_overflow), 8'd0);
  endtask

  task automatic arm_and_wait();
    arm_req = 1'b1;
    tick(1);
    arm_req = 1'b0;
    tick(16);
    check("arm.armed_state", 8'(state), 8'd2);
  endtask

  initial begin
    logic siren_seen;
    //                arm dis rdy zin    mask   hold st armd vld zone
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1,  3'd1, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 15, 3'd1, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 1,  3'd2, 1'b1, 1'b0, 3'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 2,  3'd2, 1'b1, 1'b0, 3'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 2,  3'd2, 1'b1, 1'b0, 3'd0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 3,  3'd2, 1'b1, 1'b0, 3'd0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 4'h4, 4'h0, 1,  3'd3, 1'b1, 1'b1, 3'd2};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b1, 3'd2};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b0, 3'd0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b0, 1'b0, 3'd0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 16, 3'd2, 1'b1, 1'b0, 3'd0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h2, 3,  3'd2, 1'b1, 1'b0, 3'd0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'hA, 4'h2, 1,  3'd3, 1'b1, 1'b1, 3'd3};
    vecs[13] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b0, 3'd0};
    vecs[14] = '{1'b1, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd1, 1'b0, 1'b0, 3'd0};
    vecs[15] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 16, 3'd2, 1'b1, 1'b0, 3'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 4'hA, 4'h0, 4,  3'd3, 1'b1, 1'b1, 3'd1};
    vecs[17] = '{1'b0, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b0, 3'd0};
    vecs[18] = '{1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b0, 3'd0};
    vecs[19] = '{1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 1,  3'd0, 1'b0, 1'b0, 3'd0};

    rst_n = 1'b0; arm_req = 1'b0; disarm_req = 1'b0; evt_ready = 1'b0;
    zone_in = '0; zone_mask = '0;
    tick(2);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(3);
    check("idle.state", 8'(state), 8'd0);

    for (int v = 0; v < 20; v++) begin
      arm_req    = vecs[v].arm;
      disarm_req = vecs[v].disarm;
      evt_ready  = vecs[v].ready;
      zone_in    = vecs[v].zin;
      zone_mask  = vecs[v].mask;
      tick(vecs[v].hold);
      check($sformatf("vec%0d.state", v), 8'(state), 8'(vecs[v].st));
      check($sformatf("vec%0d.armed", v), 8'(armed), 8'(vecs[v].armed));
      check($sformatf("vec%0d.valid", v), 8'(evt_valid), 8'(vecs[v].valid));
      if (vecs[v].valid) check($sformatf("vec%0d.zone", v), 8'(evt_zone), 8'(vecs[v].zone));
    end
    arm_req = 1'b0; disarm_req = 1'b0; zone_in = '0;

    // Full trip with the logger stalled, then a second trip that overflows.
    evt_ready = 1'b0;
    arm_and_wait();
    zone_in = 4'h1;
    tick(4);
    check("trip.entry", 8'(state), 8'd3);
    check("trip.valid", 8'(evt_valid), 8'd1);
    check("trip.zone", 8'(evt_zone), 8'd0);
    zone_in = 4'h0;
    tick(15);
    check("trip.last_entry", 8'(state), 8'd3);
    check("trip.siren_pre", 8'(siren), 8'd0);
    tick(1);
    check("trip.siren_state", 8'(state), 8'd4);
    check("trip.siren_on", 8'(siren), 8'd1);
    check("trip.tripped", 8'(tripped), 8'd1);
    tick(63);
    check("trip.siren_last", 8'(siren), 8'd1);
    tick(1);
    check("trip.rearmed", 8'(state), 8'd2);
    check("trip.siren_off", 8'(siren), 8'd0);
    check("trip.tripped_held", 8'(tripped), 8'd1);
    check("trip.armed", 8'(armed), 8'd1);

    zone_in = 4'h2;
    tick(4);
    check("ovf.entry", 8'(state), 8'd3);
    check("ovf.valid", 8'(evt_valid), 8'd1);
    check("ovf.zone_held", 8'(evt_zone), 8'd0);
    check("ovf.flag", 8'(evt_overflow), 8'd1);
    zone_in = 4'h0;
    evt_ready = 1'b1;
    tick(1);
    check("ovf.drained", 8'(evt_valid), 8'd0);
    check("ovf.sticky", 8'(evt_overflow), 8'd1);
    tick(15);
    check("rst.in_siren", 8'(siren), 8'd1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    tick(1);
    rst_n = 1'b1;
    tick(1);

    // Disarm on the final ENTRY cycle must keep the siren off.
    arm_and_wait();
    zone_in = 4'h1;
    tick(4);
    check("race.entry", 8'(state), 8'd3);
    zone_in = 4'h0;
    siren_seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      siren_seen |= siren;
    end
    check("race.last_entry", 8'(state), 8'd3);
    disarm_req = 1'b1;
    tick(1);
    disarm_req = 1'b0;
    check("race.disarmed", 8'(state), 8'd0);
    siren_seen |= siren;
    tick(3);
    siren_seen |= siren;
    check("race.siren_never", 8'(siren_seen), 8'd0);
    check("race.tripped", 8'(tripped), 8'd0);
    check("race.overflow", 8'(evt_overflow), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
